fp_mul_seq: RTL

- Iterative single-precision floating-point multiplier controller.
- Accepts one operand pair via valid/ready and classifies special operands.
- Sequences a 24-cycle shift-add mantissa multiply, then normalises, range-checks and packs the result.
- Holds the result until the downstream stage acknowledges it.
- Sits in FP_Mul as the multi-cycle, area-reduced alternative to the combinational multiplier path. Normalisation uses the existing MultNorm truncation rule.

---
 rtl/fp_mul_pkg.sv | 41 ++++
 rtl/fp_mul_special.sv | 48 ++++
 rtl/fp_mul_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// Shared widths, constants, state encoding and operand layout for the
// sequential single-precision multiplier.
package fp_mul_pkg;

    localparam int unsigned EXP_WIDTH  = 8;
    localparam int unsigned MANT_WIDTH = 23;
    localparam int unsigned BIAS       = 127;

    localparam int unsigned WORD_WIDTH = EXP_WIDTH + MANT_WIDTH + 1;
    localparam int unsigned SIG_WIDTH  = MANT_WIDTH + 1;
    localparam int unsigned PROD_WIDTH = 2 * SIG_WIDTH;
    localparam int unsigned EXPS_WIDTH = EXP_WIDTH + 2;
    localparam int unsigned CNT_WIDTH  = 5;
    localparam int unsigned FLAG_WIDTH = 4;

    localparam logic [WORD_WIDTH-1:0] QNAN = WORD_WIDTH'(32'h7FC0_0000);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MULT = ST_MULT,
        NORM = ST_NORM,
        DONE = ST_DONE
    } state_e;

    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [MANT_WIDTH-1:0] mant;
    } fp_t;

endpackage

// File: rtl/fp_mul_special.sv
// Classifies both operands and selects the product for any special input
// combination; denormals are treated as zero.
module fp_mul_special
    import fp_mul_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic                  special_c,
    output logic [WORD_WIDTH-1:0] result_c,
    output logic [FLAG_WIDTH-1:0] flags_c
);

    fp_t  fa;
    fp_t  fb;
    logic sign;
    logic zero_a, inf_a, nan_a;
    logic zero_b, inf_b, nan_b;

    assign fa   = a;
    assign fb   = b;
    assign sign = fa.sign ^ fb.sign;

    assign zero_a = (fa.exp == '0);
    assign inf_a  = (fa.exp == '1) && (fa.mant == '0);
    assign nan_a  = (fa.exp == '1) && (fa.mant != '0);
    assign zero_b = (fb.exp == '0);
    assign inf_b  = (fb.exp == '1) && (fb.mant == '0);
    assign nan_b  = (fb.exp == '1) && (fb.mant != '0);

    // Priority: invalid first, then infinity, then zero.
    always_comb begin
        special_c = 1'b0;
        result_c  = '0;
        flags_c   = '0;
        if (nan_a || nan_b || (zero_a && inf_b) || (inf_a && zero_b)) begin
            special_c              = 1'b1;
            result_c               = QNAN;
            flags_c[FLAG_INVALID]  = 1'b1;
        end else if (inf_a || inf_b) begin
            special_c = 1'b1;
            result_c  = {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        end else if (zero_a || zero_b) begin
            special_c = 1'b1;
            result_c  = {sign, {(WORD_WIDTH-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Iterative single-precision multiplier: shift-add mantissa product over
// 24 cycles, truncating normalisation, result held until acknowledged.
module fp_mul_seq
    import fp_mul_pkg::*;
(
    input  logic                  in_Clk,
    input  logic                  in_Rst,
    input  logic                  in_Valid,
    output logic                  out_Ready,
    input  logic [WORD_WIDTH-1:0] in_A,
    input  logic [WORD_WIDTH-1:0] in_B,
    output logic                  out_Valid,
    input  logic                  in_Ack,
    output logic [WORD_WIDTH-1:0] out_Result,
    output logic [FLAG_WIDTH-1:0] out_Flags
);

    localparam logic [EXPS_WIDTH-1:0] EXP_MAX  = EXPS_WIDTH'((1 << EXP_WIDTH) - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(SIG_WIDTH - 1);

    state_e                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [PROD_WIDTH-1:0]  acc;
    logic [SIG_WIDTH-1:0]   mcand;
    logic [SIG_WIDTH-1:0]   mplier;
    logic                   sign_q;
    logic [EXPS_WIDTH-1:0]  exp_q;

    fp_t                    fa;
    fp_t                    fb;
    logic                   special_c;
    logic [WORD_WIDTH-1:0]  special_result_c;
    logic [FLAG_WIDTH-1:0]  special_flags_c;

    logic [PROD_WIDTH-1:0]  partial_c;
    logic [EXPS_WIDTH-1:0]  exp_n_c;
    logic [MANT_WIDTH-1:0]  mant_n_c;
    logic                   inexact_n_c;
    logic [WORD_WIDTH-1:0]  norm_result_c;
    logic [FLAG_WIDTH-1:0]  norm_flags_c;

    assign fa = in_A;
    assign fb = in_B;

    fp_mul_special u_special (
        .a         (in_A),
        .b         (in_B),
        .special_c (special_c),
        .result_c  (special_result_c),
        .flags_c   (special_flags_c)
    );

    assign partial_c = mplier[0] ? (PROD_WIDTH'(mcand) << cnt) : '0;

    // Truncating normalisation and range check on the finished product.
    always_comb begin
        exp_n_c       = exp_q;
        mant_n_c      = acc[PROD_WIDTH-3 -: MANT_WIDTH];
        inexact_n_c   = |acc[PROD_WIDTH-MANT_WIDTH-3:0];
        norm_result_c = '0;
        norm_flags_c  = '0;
        if (acc[PROD_WIDTH-1]) begin
            exp_n_c     = exp_q + EXPS_WIDTH'(1);
            mant_n_c    = acc[PROD_WIDTH-2 -: MANT_WIDTH];
            inexact_n_c = |acc[PROD_WIDTH-MANT_WIDTH-2:0];
        end
        if (!exp_n_c[EXPS_WIDTH-1] && (exp_n_c >= EXP_MAX)) begin
            norm_result_c                = {sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            norm_flags_c[FLAG_OVERFLOW]  = 1'b1;
            norm_flags_c[FLAG_INEXACT]   = 1'b1;
        end else if (exp_n_c[EXPS_WIDTH-1] || (exp_n_c == '0)) begin
            norm_result_c                = {sign_q, {(WORD_WIDTH-1){1'b0}}};
            norm_flags_c[FLAG_UNDERFLOW] = 1'b1;
            norm_flags_c[FLAG_INEXACT]   = 1'b1;
        end else begin
            norm_result_c                = {sign_q, exp_n_c[EXP_WIDTH-1:0], mant_n_c};
            norm_flags_c[FLAG_INEXACT]   = inexact_n_c;
        end
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            state      <= IDLE;
            out_Ready  <= 1'b1;
            out_Valid  <= 1'b0;
            out_Result <= '0;
            out_Flags  <= '0;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_Valid && out_Ready) begin
                        sign_q    <= fa.sign ^ fb.sign;
                        mcand     <= {1'b1, fa.mant};
                        mplier    <= {1'b1, fb.mant};
                        exp_q     <= EXPS_WIDTH'(fa.exp) + EXPS_WIDTH'(fb.exp)
                                     - EXPS_WIDTH'(BIAS);
                        cnt       <= '0;
                        acc       <= '0;
                        out_Ready <= 1'b0;
                        if (special_c) begin
                            out_Result <= special_result_c;
                            out_Flags  <= special_flags_c;
                            out_Valid  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= MULT;
                        end
                    end
                end
                MULT: begin
                    acc    <= acc + partial_c;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_LAST) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    out_Result <= norm_result_c;
                    out_Flags  <= norm_flags_c;
                    out_Valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (in_Ack) begin
                        out_Valid <= 1'b0;
                        out_Ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
